// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned ENTRY_W     = 2 * XLEN;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  // Canonical RISC-V nop (addi x0, x0, 0), handy as a bubble filler.
  localparam logic [XLEN-1:0] NOP          = 32'h0000_0013;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO holding prefetched {pc, instr} entries.
// Flush wins over push and pop; push when full and pop when empty are ignored.
// When empty, data_o keeps presenting the last head that was visible.
import instr_fetch_pkg::*;

module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  last_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Head is the slot under the read pointer; once drained, hold the last head.
  assign data_o = empty_o ? last_q : mem_q[rd_q];

  // Pointer/occupancy next state; a flush discards everything, including a same-cycle pop.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = wr_q;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and last-head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (!empty_o) last_q <= mem_q[rd_q];
    end
  end

  // Entry storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, strobes instruction memory,
// buffers returned words in a prefetch FIFO and hands them to decode.
import instr_fetch_pkg::*;

module instr_fetch #(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_hold
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fifo_full, fifo_empty;
  logic            pop;
  fetch_entry_t    push_entry, head_entry;
  logic [1:0]      redirect_pc_unused;

  // Byte offset of a redirect target is dropped; fetches are always word aligned.
  assign redirect_pc_unused = redirect_pc[1:0];

  assign imem_addr = pc_q;

  // Fetch only when there is room, no redirect is pending and fetch is not held.
  // Deliberately independent of if_ready: a full FIFO stalls even if popped.
  assign imem_en = !rst && !fifo_full && !redirect_valid && !fetch_hold;

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_data;

  assign if_valid = !fifo_empty;
  assign pop      = if_valid && if_ready;
  assign if_pc    = head_entry.pc;
  assign if_instr = head_entry.instr;

  // PC next state: redirect wins, otherwise advance on every issued fetch.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = {redirect_pc[31:2], 2'b00};
    else if (imem_en)
      pc_d = next_pc(pc_q);
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (imem_en),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_hold;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory image: word n holds A000_0000 + n.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  assign imem_data = mem_fn(imem_addr);

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_hold     (fetch_hold)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic        hold;
    logic [31:0] rpc;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic rv, input logic hold, input logic [31:0] rpc,
                     input logic en, input logic [31:0] addr, input logic vld, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.hold = hold; v.rpc = rpc;
    v.en = en; v.addr = addr; v.vld = vld; v.pc = pc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_hold = 1'b0;

    //   rdy rv hold rpc           en addr          vld pc
    add(1, 0, 0, 32'h0,          1, 32'h0,        0, 32'h0);        // 0 first fetch after reset
    add(1, 0, 0, 32'h0,          1, 32'h4,        1, 32'h0);        // 1 stream
    add(1, 0, 0, 32'h0,          1, 32'h8,        1, 32'h4);        // 2
    add(1, 0, 0, 32'h0,          1, 32'hC,        1, 32'h8);        // 3
    add(0, 0, 0, 32'h0,          1, 32'h10,       1, 32'hC);        // 4 backpressure
    add(0, 0, 0, 32'h0,          0, 32'h14,       1, 32'hC);        // 5 full
    add(0, 0, 0, 32'h0,          0, 32'h14,       1, 32'hC);        // 6
    add(0, 0, 0, 32'h0,          0, 32'h14,       1, 32'hC);        // 7
    add(1, 0, 0, 32'h0,          0, 32'h14,       1, 32'hC);        // 8 full + pop: bubble
    add(1, 0, 0, 32'h0,          1, 32'h14,       1, 32'h10);       // 9 fetch resumes
    add(1, 0, 0, 32'h0,          1, 32'h18,       1, 32'h14);       // 10
    add(0, 0, 0, 32'h0,          1, 32'h1C,       1, 32'h18);       // 11 queue two
    add(1, 1, 0, 32'h42,         0, 32'h20,       1, 32'h18);       // 12 redirect + pop
    add(1, 0, 0, 32'h0,          1, 32'h40,       0, 32'h0);        // 13 flushed
    add(1, 0, 0, 32'h0,          1, 32'h44,       1, 32'h40);       // 14 new head
    add(1, 0, 0, 32'h0,          1, 32'h48,       1, 32'h44);       // 15
    add(1, 1, 0, 32'hFFFF_FFF8,  0, 32'h4C,       1, 32'h48);       // 16 redirect near top
    add(1, 0, 0, 32'h0,          1, 32'hFFFF_FFF8, 0, 32'h0);       // 17
    add(1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8); // 18
    add(1, 0, 0, 32'h0,          1, 32'h0,        1, 32'hFFFF_FFFC); // 19 wrap
    add(1, 0, 0, 32'h0,          1, 32'h4,        1, 32'h0);        // 20
    add(1, 0, 1, 32'h0,          0, 32'h8,        1, 32'h4);        // 21 hold, drain
    add(1, 0, 1, 32'h0,          0, 32'h8,        0, 32'h0);        // 22 drained, pc frozen
    add(0, 0, 0, 32'h0,          1, 32'h8,        0, 32'h0);        // 23 release hold
    add(0, 1, 1, 32'h103,        0, 32'hC,        1, 32'h8);        // 24 redirect during hold
    add(0, 0, 1, 32'h0,          0, 32'h100,      0, 32'h0);        // 25
    add(1, 0, 0, 32'h0,          1, 32'h100,      0, 32'h0);        // 26
    add(1, 0, 0, 32'h0,          1, 32'h104,      1, 32'h100);      // 27

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en",    {31'b0, imem_en},  32'h0);
    chk("rst_addr",  imem_addr,         32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_pc",    if_pc,             32'h0);
    chk("rst_instr", if_instr,          32'h0);

    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      if_ready = tbl[i].rdy; redirect_valid = tbl[i].rv;
      fetch_hold = tbl[i].hold; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_en", i),    {31'b0, imem_en},  {31'b0, tbl[i].en});
      chk($sformatf("v%0d_addr", i),  imem_addr,         tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].vld});
      if (tbl[i].vld) begin
        chk($sformatf("v%0d_pc", i),    if_pc,    tbl[i].pc);
        chk($sformatf("v%0d_instr", i), if_instr, mem_fn(tbl[i].pc));
      end
    end

    // Drained FIFO keeps showing the last head (0x104 after row 27 pops 0x100).
    @(negedge clk);
    if_ready = 1'b1; fetch_hold = 1'b1; redirect_valid = 1'b0;
    #1;
    chk("hold_head_pc", if_pc, 32'h104);
    @(negedge clk);
    #1;
    chk("hold_empty_valid", {31'b0, if_valid}, 32'h0);
    chk("hold_last_pc",     if_pc,             32'h104);

    // Async reset between edges: outputs return without any clock edge.
    fetch_hold = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_en",    {31'b0, imem_en},  32'h0);
    chk("arst_addr",  imem_addr,         32'h0);
    chk("arst_valid", {31'b0, if_valid}, 32'h0);
    chk("arst_pc",    if_pc,             32'h0);
    chk("arst_instr", if_instr,          32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("restart_en",   {31'b0, imem_en}, 32'h1);
    chk("restart_addr", imem_addr,        32'h0);
    @(negedge clk);
    #1;
    chk("restart_valid", {31'b0, if_valid}, 32'h1);
    chk("restart_pc",    if_pc,             32'h0);
    chk("restart_instr", if_instr,          32'hA000_0000);
    chk("restart_addr2", imem_addr,         32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
